onehot_hold_decoder: RTL

Sequential binary-to-one-hot decoder: the inverse of the lab's priority encoder. It accepts a binary index over a valid/ready handshake and drives the matching one-hot line of `Y` for exactly `HOLD` clock cycles, then releases it. It sits between control logic that produces an encoded select and the one-hot loads it drives (LED/digit enables, strobe lines, mux selects). Back-to-back requests produce gap-free output, and out-of-range codes are flagged rather than decoded.

---
 rtl/onehot_hold_decoder_if.sv | 26 ++
 rtl/onehot_hold_decoder.sv | 115 +++++++++++
 2 files changed

// File: rtl/onehot_hold_decoder_if.sv
// Handshake/bus bundle for onehot_hold_decoder: binary index in, one-hot out.
interface onehot_hold_decoder_if #(
  parameter int N = 4
);
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  logic [AW-1:0] A;
  logic          a_valid;
  logic          a_ready;
  logic          abort;
  logic [N-1:0]  Y;
  logic          busy;
  logic          err;

  // Producer side: supplies the index and cancel, observes the decoded output.
  modport master (
    output A, a_valid, abort,
    input  a_ready, Y, busy, err
  );

  // Decoder side.
  modport slave (
    input  A, a_valid, abort,
    output a_ready, Y, busy, err
  );
endinterface

// File: rtl/onehot_hold_decoder.sv
// Sequential binary-to-one-hot decoder. Each accepted index drives its one-hot
// line for HOLD cycles; a new code may be taken on the last drive cycle so
// back-to-back requests produce gap-free output. Out-of-range codes pulse err.
module onehot_hold_decoder #(
  parameter int N    = 4,
  parameter int HOLD = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  onehot_hold_decoder_if.slave  bus
);
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = ($clog2(HOLD + 1) > 0) ? $clog2(HOLD + 1) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  y_q, y_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [AW-1:0] a_idx;
  logic [N-1:0]  a_onehot;
  logic          a_in_range;
  logic          a_ready;
  logic          xfer;

  assign a_idx = bus.A;

  // One decode comparator per output line; codes >= N leave every bit low.
  for (genvar gi = 0; gi < N; gi++) begin : g_dec
    assign a_onehot[gi] = (a_idx == AW'(gi));
  end

  // Widen by one bit so the range test still works when N is a power of two.
  assign a_in_range = ({1'b0, a_idx} < (AW + 1)'(N));

  // Ready depends only on state and abort, never on a_valid.
  assign a_ready = !bus.abort &&
                   ((state_q == IDLE) || ((state_q == DRIVE) && (cnt_q == '0)));
  assign xfer    = bus.a_valid && a_ready;

  // Next-state and output computation; abort wins over everything else.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    if (bus.abort) begin
      state_d = IDLE;
      y_d     = '0;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else if (xfer) begin
      if (a_in_range) begin
        // Same load path from IDLE and from the last DRIVE cycle, so the
        // output switches straight to the new line with no zero cycle.
        state_d = DRIVE;
        y_d     = a_onehot;
        busy_d  = 1'b1;
        cnt_d   = CW'(HOLD - 1);
      end else begin
        state_d = IDLE;
        y_d     = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        err_d   = 1'b1;
      end
    end else begin
      case (state_q)
        DRIVE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            state_d = IDLE;
            y_d     = '0;
            busy_d  = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset clears the drive immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.a_ready = a_ready;
  assign bus.Y       = y_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;

endmodule
